count_master: RTL and testbench
===============================

# count_master

Initiator for the go/done counter handshake. It turns a debounced active-low start button into a held active-low go request and waits for the counter's done pulse, with an optional timeout. It tallies completed runs on LEDs. It sits on the Icestick 12 MHz clock domain beside the counter block, whose done output comes from a divided clock and is treated here as asynchronous.

## Interface
- DEBOUNCE_CYCLES, 120000: cycles a synchronized button level must hold before it is accepted (10 ms).
- GO_HOLD_CYCLES, 3000002: cycles go_n is held low; covers one full divided-clock period of the counter.
- TIMEOUT_CYCLES, 60000000: maximum cycles spent in WAIT_DONE (5 s).
- clk  in  1  12 MHz system clock.
- rst  in  1  Reset: asynchronous, active-high.
- start_btn  in  1  Start button, active-low, asynchronous, bouncy.
- done_sig  in  1  Done from the counter, active-high, asynchronous to clk.
- go_n  out  1  Go request to the counter, active-low; reset 1.
- busy  out  1  High in ARM and WAIT_DONE; reset 0.
- run_count  out  4  Completed-run tally for the LEDs; reset 0.
- fault  out  1  Timeout indicator; reset 0.

## Operation
- Input conditioning:
  - start_btn and done_sig each pass through a 2-flop synchronizer; start is inverted after synchronization.
  - Debouncer: a counter of width clog2(DEBOUNCE_CYCLES) counts while the synchronized level differs from the stable level.
  - The counter clears when the levels match. When it reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears.
  - press is a 1-cycle pulse on a stable 0->1 transition.
  - done_rise is a 1-cycle pulse on a 0->1 transition of the synchronized done.
- FSM with a shared down-counter `tmr`, sized for the larger of GO_HOLD_CYCLES and TIMEOUT_CYCLES.
  - IDLE: on press, go to ARM and load tmr = GO_HOLD_CYCLES-1.
  - ARM: go_n=0. Decrement tmr; at tmr==0, go to WAIT_DONE and load tmr = TIMEOUT_CYCLES-1. done_rise in ARM is ignored as stale.
  - WAIT_DONE: go_n=1.
    - On done_rise, go to COMPLETE.
    - Else if tmr==0, go to FAULT.
    - Else decrement tmr.
  - COMPLETE: one cycle. run_count <= run_count+1, wrapping 4'hF -> 4'h0. Then go to IDLE.
  - FAULT: fault=1, go_n=1.
    - On press, clear fault, go to ARM and load GO_HOLD_CYCLES-1. This press both acknowledges the fault and starts a new run.
  - Unused encodings go to IDLE.
- press while busy=1 is ignored and not queued.
- If done_rise and timer expiry occur in the same WAIT_DONE cycle, done wins and the state goes to COMPLETE.
- rst at any time forces IDLE and all output reset values within the same cycle, and clears the synchronizers, the debouncer and tmr.

## Timing
- All outputs are registered; no combinational path from input to output.
- press occurs 2 + DEBOUNCE_CYCLES cycles after start_btn falls and then stays stable.
- go_n falls on the clk edge after press. It stays low for exactly GO_HOLD_CYCLES cycles.
- busy rises with go_n falling. It falls on the edge entering COMPLETE or FAULT.
- done_rise is seen 3 cycles after done_sig rises. run_count updates 2 cycles after done_rise: 1 cycle to enter COMPLETE, then 1 cycle for the count register.
- fault rises TIMEOUT_CYCLES cycles after go_n returns high when no done arrives.

## Configuration
- Macro TIMEOUT_EN.
- Defined: timeout logic as above.
- Undefined:
  - WAIT_DONE waits indefinitely for done_rise.
  - The FAULT state is removed, fault is tied 0, and tmr is sized for GO_HOLD_CYCLES only.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, GO_HOLD_CYCLES=8, TIMEOUT_CYCLES=50.
- Reset: assert rst mid-ARM -> go_n=1, busy=0, run_count=0, fault=0 immediately; FSM in IDLE after release.
- Normal run: press start (low 20 cycles), pulse done high for 5 cycles 20 cycles after go_n rises -> go_n low exactly 8 cycles, busy falls, run_count=1, fault=0.
- Bounce and ignore:
  - Toggle start_btn every 2 cycles for 12 cycles, then release -> no go_n assertion.
  - Press during WAIT_DONE -> no second go.
- Wrap: 16 complete runs -> run_count goes 15 then 0.
- Timeout (TIMEOUT_EN): no done after press -> fault=1 exactly 50 cycles after go_n rises. Next press -> fault=0 and go_n low for 8 cycles.
- Boundary:
  - done_rise coincides with the tmr==0 cycle -> COMPLETE, fault stays 0.
  - done high during ARM only -> ignored, later timeout.

Source files
------------

// File: rtl/count_master.sv
// count_master: turns a debounced active-low start button into a held go_n request,
// waits for the counter's done pulse and tallies runs. Define TIMEOUT_EN for timeout/FAULT.

module count_master #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int GO_HOLD_CYCLES  = 3000002,
  parameter int TIMEOUT_CYCLES  = 60000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       done_sig,
  output logic       go_n,
  output logic       busy,
  output logic [3:0] run_count,
  output logic       fault
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
`ifdef TIMEOUT_EN
  localparam int TMR_MAX = (GO_HOLD_CYCLES > TIMEOUT_CYCLES) ? GO_HOLD_CYCLES : TIMEOUT_CYCLES;
`else
  localparam int TMR_MAX = GO_HOLD_CYCLES;
`endif
  localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GO_LOAD = TMR_W'(GO_HOLD_CYCLES - 1);
`ifdef TIMEOUT_EN
  localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARM      = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_COMPLETE = 3'd3;
  localparam logic [2:0] S_FAULT    = 3'd4;

  logic [1:0]       r_start_sync;
  logic [1:0]       r_done_sync;
  logic             r_done_d;
  logic             r_done_rise;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_stable;
  logic             r_press;
  logic             w_start_lvl;

  logic [2:0]       r_state;
  logic [TMR_W-1:0] r_tmr;
  logic             r_go_n;
  logic             r_busy;
  logic [3:0]       r_run_count;

  // The button is active-low; work with a pressed=1 level from here on.
  assign w_start_lvl = ~r_start_sync[1];

  // NOTE: every sequential update uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_sync <= '0;
      r_done_sync  <= '0;
      r_done_d     <= 1'b0;
      r_done_rise  <= 1'b0;
      r_db_cnt     <= '0;
      r_stable     <= 1'b0;
      r_press      <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[0], start_btn};
      r_done_sync  <= {r_done_sync[0], done_sig};
      r_done_d     <= r_done_sync[1];
      r_done_rise  <= r_done_sync[1] & ~r_done_d;
      r_press      <= 1'b0;
      if (w_start_lvl == r_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_stable <= w_start_lvl;
        r_db_cnt <= '0;
        r_press  <= w_start_lvl;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

`ifdef TIMEOUT_EN
  logic r_fault;
  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_go_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_run_count <= '0;
`ifdef TIMEOUT_EN
      r_fault     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_press) begin
            r_state <= S_ARM;
            r_tmr   <= GO_LOAD;
            r_go_n  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_ARM: begin
          // done_rise here belongs to a previous request and is dropped.
          if (r_tmr == '0) begin
            r_state <= S_WAIT;
            r_go_n  <= 1'b1;
`ifdef TIMEOUT_EN
            r_tmr   <= TO_LOAD;
`endif
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_WAIT: begin
          if (r_done_rise) begin
            r_state <= S_COMPLETE;
            r_busy  <= 1'b0;
`ifdef TIMEOUT_EN
          end else if (r_tmr == '0) begin
            r_state <= S_FAULT;
            r_busy  <= 1'b0;
            r_fault <= 1'b1;
          end else begin
            r_tmr <= r_tmr - 1'b1;
`endif
          end
        end
        S_COMPLETE: begin
          r_run_count <= r_run_count + 4'd1;
          r_state     <= S_IDLE;
        end
`ifdef TIMEOUT_EN
        S_FAULT: begin
          // A press both acknowledges the fault and launches the next run.
          if (r_press) begin
            r_fault <= 1'b0;
            r_state <= S_ARM;
            r_tmr   <= GO_LOAD;
            r_go_n  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_go_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign go_n      = r_go_n;
  assign busy      = r_busy;
  assign run_count = r_run_count;

endmodule

// File: tb/tb_count_master.sv
// Directed bench for count_master with DEBOUNCE=4, GO_HOLD=8, TIMEOUT=50.
// Timeout scenarios are compiled only when TIMEOUT_EN is defined.

module tb_count_master;

  logic       clk;
  logic       rst;
  logic       start_btn;
  logic       done_sig;
  logic       go_n;
  logic       busy;
  logic [3:0] run_count;
  logic       fault;

  int total = 0;
  int bad   = 0;

  // Observations from the latest drive_run, as cycle indices (-1 = never seen).
  int   fall_at, rise_at, low_cnt, busy_fall_at, rc_at, fault_at, fault_fall_at, go_falls;
  logic fault_at_fall;
  logic [3:0] exp_rc;

  count_master #(
    .DEBOUNCE_CYCLES(4),
    .GO_HOLD_CYCLES (8),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_btn(start_btn),
    .done_sig (done_sig),
    .go_n     (go_n),
    .busy     (busy),
    .run_count(run_count),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic btn_level(input int i, input int p1, input int p2s, input int p2e,
                                     input bit bounce);
    logic low;
    low = (i < p1) && (!bounce || ((i / 2) % 2 == 0));
    low = low || (i >= p2s && i < p2e);
    return ~low;
  endfunction

  // Inputs driven at negedge i reach the DUT on posedge i+1; outputs sampled at negedge i
  // reflect posedge i. Press first low at index 0.
  task automatic drive_run(input int p1, input int p2s, input int p2e, input bit bounce,
                           input int done_at, input int done_len, input int ncyc);
    logic prev_go, prev_busy, prev_fault;
    logic [3:0] rc0;
    fall_at = -1; rise_at = -1; low_cnt = 0; busy_fall_at = -1; rc_at = -1;
    fault_at = -1; fault_fall_at = -1; go_falls = 0; fault_at_fall = 1'b0;
    rc0 = run_count; prev_go = go_n; prev_busy = busy; prev_fault = fault;
    start_btn = btn_level(0, p1, p2s, p2e, bounce);
    done_sig  = (done_at == 0 && done_len > 0);
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (go_n === 1'b0 && prev_go === 1'b1) begin
        go_falls++;
        if (fall_at < 0) begin
          fall_at = i;
          fault_at_fall = fault;
        end
      end
      if (go_n === 1'b0) low_cnt++;
      if (go_n === 1'b1 && prev_go === 1'b0 && rise_at < 0) rise_at = i;
      if (busy === 1'b0 && prev_busy === 1'b1 && busy_fall_at < 0) busy_fall_at = i;
      if (run_count !== rc0 && rc_at < 0) rc_at = i;
      if (fault === 1'b1 && prev_fault === 1'b0 && fault_at < 0) fault_at = i;
      if (fault === 1'b0 && prev_fault === 1'b1 && fault_fall_at < 0) fault_fall_at = i;
      prev_go = go_n; prev_busy = busy; prev_fault = fault;
      start_btn = btn_level(i, p1, p2s, p2e, bounce);
      done_sig  = (done_at >= 0 && i >= done_at && i < done_at + done_len);
    end
    start_btn = 1'b1;
    done_sig  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_btn = 1'b1; done_sig = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({go_n, busy, run_count, fault} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_state: got go_n=%b busy=%b rc=%0d fault=%b want 1 0 0 0",
               go_n, busy, run_count, fault);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_rc = 4'd0;
  endtask

  task automatic test_normal;
    drive_run(20, 0, 0, 1'b0, 35, 5, 60);
    exp_rc = exp_rc + 4'd1;
    total++;
    if (fall_at !== 7) begin bad++; $display("FAIL normal_go_fall: got %0d want 7", fall_at); end
    total++;
    if (low_cnt !== 8) begin bad++; $display("FAIL normal_go_len: got %0d want 8", low_cnt); end
    total++;
    if (rise_at !== 15) begin bad++; $display("FAIL normal_go_rise: got %0d want 15", rise_at); end
    total++;
    if (busy_fall_at !== 39) begin bad++; $display("FAIL normal_busy_fall: got %0d want 39", busy_fall_at); end
    total++;
    if (rc_at !== 40) begin bad++; $display("FAIL normal_rc_time: got %0d want 40", rc_at); end
    total++;
    if (run_count !== exp_rc) begin bad++; $display("FAIL normal_rc: got %0d want %0d", run_count, exp_rc); end
    total++;
    if (fault !== 1'b0) begin bad++; $display("FAIL normal_fault: got %b want 0", fault); end
  endtask

  task automatic test_reset_mid_arm;
    drive_run(7, 0, 0, 1'b0, -1, 0, 10);
    total++;
    if (go_n !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_arm_setup: got go_n=%b busy=%b want 0 1", go_n, busy);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({go_n, busy, run_count, fault} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_async: got go_n=%b busy=%b rc=%0d fault=%b want 1 0 0 0",
               go_n, busy, run_count, fault);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_rc = 4'd0;
    drive_run(0, 0, 0, 1'b0, -1, 0, 20);
    total++;
    if (go_falls !== 0 || go_n !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got falls=%0d go_n=%b busy=%b want 0 1 0", go_falls, go_n, busy);
    end
  endtask

  task automatic test_bounce;
    drive_run(12, 0, 0, 1'b1, -1, 0, 40);
    total++;
    if (go_falls !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL bounce_no_go: got falls=%0d busy=%b want 0 0", go_falls, busy);
    end
  endtask

  task automatic test_press_in_wait;
    drive_run(8, 20, 30, 1'b0, 45, 3, 70);
    exp_rc = exp_rc + 4'd1;
    total++;
    if (go_falls !== 1) begin bad++; $display("FAIL wait_press_falls: got %0d want 1", go_falls); end
    total++;
    if (busy_fall_at !== 49 || rc_at !== 50) begin
      bad++; $display("FAIL wait_press_done: got busy_fall=%0d rc_at=%0d want 49 50", busy_fall_at, rc_at);
    end
    total++;
    if (run_count !== exp_rc) begin bad++; $display("FAIL wait_press_rc: got %0d want %0d", run_count, exp_rc); end
  endtask

  task automatic test_wrap;
    for (int r = 0; r < 16; r++) begin
      drive_run(8, 0, 0, 1'b0, 16, 2, 30);
      exp_rc = exp_rc + 4'd1;
      total++;
      if (run_count !== exp_rc || rc_at !== 21) begin
        bad++;
        $display("FAIL wrap_run%0d: got rc=%0d at %0d want %0d at 21", r, run_count, rc_at, exp_rc);
      end
    end
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout;
    drive_run(8, 0, 0, 1'b0, -1, 0, 80);
    total++;
    if (rise_at !== 15 || fault_at !== 65) begin
      bad++; $display("FAIL timeout_fault: got rise=%0d fault=%0d want 15 65", rise_at, fault_at);
    end
    total++;
    if (busy_fall_at !== 65 || rc_at !== -1) begin
      bad++; $display("FAIL timeout_busy: got busy_fall=%0d rc_at=%0d want 65 -1", busy_fall_at, rc_at);
    end
    drive_run(8, 0, 0, 1'b0, 20, 2, 40);
    exp_rc = exp_rc + 4'd1;
    total++;
    if (fault_fall_at !== 7 || fault_at_fall !== 1'b0 || fall_at !== 7) begin
      bad++;
      $display("FAIL fault_ack: got fault_fall=%0d fault=%b go_fall=%0d want 7 0 7",
               fault_fall_at, fault_at_fall, fall_at);
    end
    total++;
    if (low_cnt !== 8 || run_count !== exp_rc) begin
      bad++; $display("FAIL fault_rerun: got low=%0d rc=%0d want 8 %0d", low_cnt, run_count, exp_rc);
    end
  endtask
`endif

  task automatic test_boundary;
`ifdef TIMEOUT_EN
    // done_rise lands on the tmr==0 cycle: done must win.
    drive_run(8, 0, 0, 1'b0, 61, 2, 80);
    exp_rc = exp_rc + 4'd1;
    total++;
    if (busy_fall_at !== 65 || rc_at !== 66 || fault_at !== -1) begin
      bad++;
      $display("FAIL tie_done_wins: got busy_fall=%0d rc_at=%0d fault_at=%0d want 65 66 -1",
               busy_fall_at, rc_at, fault_at);
    end
    // One cycle later is too late.
    drive_run(8, 0, 0, 1'b0, 62, 2, 80);
    total++;
    if (fault_at !== 65 || rc_at !== -1) begin
      bad++; $display("FAIL late_done_faults: got fault_at=%0d rc_at=%0d want 65 -1", fault_at, rc_at);
    end
    // Launched from FAULT; done only during ARM is stale.
    drive_run(8, 0, 0, 1'b0, 9, 2, 80);
    total++;
    if (fall_at !== 7 || fault_at !== 65 || rc_at !== -1) begin
      bad++;
      $display("FAIL arm_done_ignored: got fall=%0d fault_at=%0d rc_at=%0d want 7 65 -1",
               fall_at, fault_at, rc_at);
    end
    drive_run(8, 0, 0, 1'b0, 20, 2, 40);
    exp_rc = exp_rc + 4'd1;
    total++;
    if (fault !== 1'b0 || run_count !== exp_rc) begin
      bad++; $display("FAIL boundary_cleanup: got fault=%b rc=%0d want 0 %0d", fault, run_count, exp_rc);
    end
`else
    drive_run(8, 0, 0, 1'b0, 9, 2, 80);
    total++;
    if (rc_at !== -1 || busy !== 1'b1 || go_n !== 1'b1 || fault !== 1'b0) begin
      bad++;
      $display("FAIL arm_done_ignored: got rc_at=%0d busy=%b go_n=%b fault=%b want -1 1 1 0",
               rc_at, busy, go_n, fault);
    end
    drive_run(0, 0, 0, 1'b0, 1, 2, 10);
    exp_rc = exp_rc + 4'd1;
    total++;
    if (busy_fall_at !== 5 || rc_at !== 6 || run_count !== exp_rc) begin
      bad++;
      $display("FAIL wait_forever_done: got busy_fall=%0d rc_at=%0d rc=%0d want 5 6 %0d",
               busy_fall_at, rc_at, run_count, exp_rc);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_normal;
    test_reset_mid_arm;
    test_bounce;
    test_press_in_wait;
    test_wrap;
`ifdef TIMEOUT_EN
    test_timeout;
`endif
    test_boundary;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
